// File: rtl/onehot_scan_encoder_if.sv
// rtl/onehot_scan_encoder_if.sv - handshake bundle between a vector source/result sink and the scan encoder
//
// Ports carried (N = 2**WIDTH):
//   in_valid   source -> encoder  in_data is offered
//   in_ready   encoder -> source  encoder can take a vector this cycle
//   in_data    source -> encoder  N-bit vector, bit i is index i
//   out_valid  encoder -> sink    result fields hold a completed result
//   out_ready  sink -> encoder    sink takes the result this cycle
//   out_index  encoder -> sink    lowest set index (0 for an empty vector)
//   out_count  encoder -> sink    population count, 0..N
//   out_onehot encoder -> sink    exactly one bit was set
//   out_zero   encoder -> sink    no bit was set
// Modports: master = source/sink side, slave = encoder side.
interface onehot_scan_encoder_if #(
    parameter int WIDTH = 4
);
    localparam int N = 2 ** WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_index;
    logic [WIDTH:0]   out_count;
    logic             out_onehot;
    logic             out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_count, out_onehot, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_count, out_onehot, out_zero
    );
endinterface

// File: rtl/onehot_scan_encoder.sv
// rtl/onehot_scan_encoder.sv - sequential lowest-index / popcount encoder scanning one bit per clock
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  onehot_scan_encoder_if.slave: input vector handshake (in_*) and
//        result handshake (out_*); see the interface file for fields.
// A vector is captured on acceptance, scanned over exactly N cycles and the
// result is held in DONE until the sink takes it.
module onehot_scan_encoder #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    onehot_scan_encoder_if.slave   bus
);
    localparam int N = 2 ** WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [N-1:0]     vec;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] index;
    logic [WIDTH:0]   count;
    logic             found;
    logic             onehot;
    logic             zero;

    logic             bit_set;
    logic             last_bit;
    logic [WIDTH:0]   count_inc;

    assign bit_set   = vec[cnt];
    assign last_bit  = (cnt == WIDTH'(N - 1));
    assign count_inc = count + (WIDTH + 1)'(bit_set);

    // Handshake outputs depend only on state and rst, never on in_valid/out_ready.
    assign bus.in_ready   = (state == IDLE) && !rst;
    assign bus.out_valid  = (state == DONE) && !rst;
    assign bus.out_index  = index;
    assign bus.out_count  = count;
    assign bus.out_onehot = onehot;
    assign bus.out_zero   = zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = SCAN;
            SCAN:    if (last_bit)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec    <= '0;
            cnt    <= '0;
            index  <= '0;
            count  <= '0;
            found  <= 1'b0;
            onehot <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec    <= bus.in_data;
                        cnt    <= '0;
                        index  <= '0;
                        count  <= '0;
                        found  <= 1'b0;
                        onehot <= 1'b0;
                        zero   <= 1'b0;
                    end
                end
                SCAN: begin
                    count <= count_inc;
                    if (bit_set && !found) begin
                        found <= 1'b1;
                        index <= cnt;
                    end
                    // The counter wraps to 0 on the same edge that leaves SCAN.
                    cnt <= cnt + WIDTH'(1);
                    if (last_bit) begin
                        onehot <= (count_inc == (WIDTH + 1)'(1));
                        zero   <= (count_inc == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onehot_scan_encoder.sv
// tb/tb_onehot_scan_encoder.sv - directed self-checking bench for onehot_scan_encoder
module tb_onehot_scan_encoder;
    localparam int WIDTH = 4;
    localparam int N     = 2 ** WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    onehot_scan_encoder_if #(.WIDTH(WIDTH)) bus ();

    onehot_scan_encoder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer v from a negedge until in_ready, return the cycle stamp of the accept edge.
    task automatic send(input logic [N-1:0] v, output int acc);
        int k;
        acc = -1;
        for (k = 0; k < 50; k++) begin
            if (bus.in_ready === 1'b1) break;
            @(negedge clk);
        end
        if (k == 50) begin
            check("send_timeout", 32'd0, 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_valid(output int at);
        int k;
        at = -1;
        for (k = 0; k < 60; k++) begin
            if (bus.out_valid === 1'b1) begin
                at = cyc;
                return;
            end
            @(negedge clk);
        end
        check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [N-1:0] v, input int e_idx,
                           input int e_cnt, input logic e_oh, input logic e_z, output int acc);
        int at;
        send(v, acc);
        wait_valid(at);
        check({tag, "_latency"}, at - acc, N);
        check({tag, "_index"},  bus.out_index, e_idx);
        check({tag, "_count"},  bus.out_count, e_cnt);
        check({tag, "_onehot"}, bus.out_onehot, e_oh);
        check({tag, "_zero"},   bus.out_zero, e_z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        int at;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset for two edges.
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        check("rst_out_count", bus.out_count, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_flags", {bus.out_onehot, bus.out_zero}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);

        // Single one-hot vector.
        run_vec("single", 16'h0008, 3, 1, 1'b1, 1'b0, acc);

        // Round trip of decoder outputs, back to back.
        prev = -1;
        for (int e = 0; e < N; e++) begin
            logic [N-1:0] d;
            d = '0;
            d[e] = 1'b1;
            send(d, acc);
            if (prev >= 0) check($sformatf("sweep%0d_spacing", e), acc - prev, 18);
            prev = acc;
            wait_valid(at);
            check($sformatf("sweep%0d_index", e), bus.out_index, e);
            check($sformatf("sweep%0d_onehot", e), bus.out_onehot, 1);
        end

        // Edge vectors.
        run_vec("zero",   16'h0000, 0, 0,  1'b0, 1'b1, acc);
        run_vec("ones",   16'hFFFF, 0, 16, 1'b0, 1'b0, acc);
        run_vec("h8100",  16'h8100, 8, 2,  1'b0, 1'b0, acc);
        run_vec("h8000",  16'h8000, 15, 1, 1'b1, 1'b0, acc);

        // Backpressure with a competing in_valid.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(16'h0110, acc);
        wait_valid(at);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0001;
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", i), bus.out_valid, 1);
            check($sformatf("bp%0d_in_ready", i), bus.in_ready, 0);
            check($sformatf("bp%0d_index", i), bus.out_index, 4);
            check($sformatf("bp%0d_count", i), bus.out_count, 2);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_out_valid", bus.out_valid, 0);

        // Reset during SCAN cycle 7.
        send(16'h0001, acc);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check("midrst_no_out_valid", seen, 0);
        run_vec("after_rst", 16'h0020, 5, 1, 1'b1, 1'b0, acc);

        // in_data changes after acceptance must not matter.
        send(16'h0004, acc);
        bus.in_data = 16'h0001;
        wait_valid(at);
        check("late_data_index", bus.out_index, 2);
        check("late_data_count", bus.out_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
